mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port `processor_memory` (16-bit word address, 32-bit data, fixed read latency) between two requesters.
  - Instruction fetch (IF), driven from `program_counter` output.
  - Load/store unit (LS).
- Grants at most one access per cycle.
- Tracks in-flight reads so each returned `mem_q` word goes back to the requester that issued it.
- Sits between the core's fetch/LSU logic and the memory instance in the `RISC_V` top.

Parameters:
- ADDR_W, 16, memory word-address width.
- DATA_W, 32, data width (equals WORD_SIZE).
- RD_LAT, 1, cycles from granted read to valid `mem_q`; legal range 1..3.

Ports:
- clk  in  1  system clock (divided clock in top).
- rst  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch read data valid.
- if_rdata  out  DATA_W  fetch read data.
- ls_req  in  1  load/store request.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_gnt  out  1  load/store accepted this cycle.
- ls_rvalid  out  1  load data valid.
- ls_rdata  out  DATA_W  load data.
- mem_address  out  ADDR_W  to memory address.
- mem_data  out  DATA_W  to memory write data.
- mem_wren  out  1  to memory write enable.
- mem_q  in  DATA_W  from memory read data.

Behaviour:
- Clock and reset:
  - One clock domain.
  - `rst` low asynchronously clears all state.
  - While `rst` is low, `if_gnt`, `ls_gnt`, `mem_wren`, `if_rvalid` and `ls_rvalid` are 0, and `mem_address`/`mem_data` are 0.
- Grant logic:
  - Grants are combinational from `req` and the `last_owner` register.
  - Only IF requesting → IF granted. Only LS requesting → LS granted.
  - Both requesting → round-robin: the owner not granted most recently wins.
  - `last_owner` updates on every grant. Its reset value is LS, so IF wins the first conflict.
- Handshake:
  - A requester holds `req`, `addr` (and `we`/`wdata`) stable until it sees `gnt` high at a clock edge.
  - A transfer happens on the cycle `req && gnt`.
  - Deasserting `req` before `gnt` is legal; the request is dropped with no side effects.
- Memory drive:
  - `mem_address` = granted address; `mem_wren` = `ls_we` when LS is granted, else 0.
  - `mem_data` = `ls_wdata` when LS is granted, else 0.
  - With no grant: address 0, `wren` 0.
- Read-tag pipeline:
  - RD_LAT-deep shift register of {valid, owner}.
  - A granted read (IF, or LS with `ls_we` = 0) enters {1, owner}; writes and idle cycles enter {0, x}.
- Read return:
  - Exactly RD_LAT cycles after a granted read, the matching `*_rvalid` pulses high for 1 cycle.
  - During that pulse `*_rdata` = `mem_q`.
  - The non-selected `rdata` is held at its last value; `rdata` is don't-care when `rvalid` = 0.
- Pipelining: back-to-back grants every cycle are supported, giving full throughput of one access per cycle.
- Boundary cases:
  - Read and write to the same address on consecutive cycles: memory semantics apply; the arbiter adds no forwarding.
  - Stores never produce `rvalid`.
  - Reset mid-operation flushes the tag pipeline: reads granted before reset never produce `rvalid`.
  - Address wrap is not the arbiter's concern; addresses pass through unchanged.

Optional Feature:
- Macro: MEM_ARB_LS_PRIORITY_EN.
- Defined: fixed priority, LS always wins a conflict and `last_owner` is unused; IF may starve while LS requests continuously.
- Undefined (default): round-robin as above.
- Tag pipeline and latency behaviour are identical in both modes.

Decomposition:
- Package `mem_arb_pkg`:
  - Owner encoding: OWN_IF = 1'b0, OWN_LS = 1'b1.
  - RD_LAT minimum/maximum constants (1, 3).
  - Typedef for the tag struct {valid, owner}.
- One sub-module `rd_tag_pipe`: parameterised RD_LAT shift register of tags with async active-low clear, exposing the head tag.

Test Plan:
- Reset then IF-only read, `if_addr` = 0x0004, RD_LAT = 1, `mem_q` = 0xDEADBEEF → `if_gnt` = 1 in cycle 0; `if_rvalid` = 1 and `if_rdata` = 0xDEADBEEF in cycle 1; `ls_rvalid` stays 0.
- Both request for 4 cycles, IF reads 0x0010, LS loads 0x0020 → grants alternate IF, LS, IF, LS; `rvalid`s alternate with the same ordering, delayed by RD_LAT.
- LS store, `ls_addr` = 0x0030, `ls_wdata` = 0x12345678 → `mem_wren` = 1, `mem_data` = 0x12345678 for one cycle; no `rvalid` on either side; an LS load of 0x0030 next cycle returns 0x12345678.
- RD_LAT = 3, IF reads issued on 3 consecutive cycles → 3 consecutive `if_rvalid` pulses starting 3 cycles after the first grant, data in issue order.
- Assert `rst` low 1 cycle after a granted IF read (RD_LAT = 2) → no `if_rvalid` after reset release; all outputs 0 during reset.
- With MEM_ARB_LS_PRIORITY_EN defined, both requesting continuously for 5 cycles → `ls_gnt` = 1 every cycle, `if_gnt` = 0 throughout.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   owner_e  : which requester owns an access (IF = 0, LS = 1)
//   RD_LAT_MIN / RD_LAT_MAX : supported read-latency range
//   rd_tag_t : per-cycle read tag {valid, owner} carried down the tag pipe
package mem_arb_pkg;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 3;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-tag delay line: RD_LAT-deep shift register of {valid, owner} tags.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low clear (flushes all in-flight tags)
//   tag_in   : tag for the access granted this cycle
//   tag_head : tag for the access whose read data is on mem_q this cycle
module rd_tag_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_head
);

  // Out-of-range latencies are clamped so the pipe always elaborates.
  localparam int unsigned DEPTH = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                                  (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

  rd_tag_t stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_head = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port processor memory between instruction fetch (IF)
// and the load/store unit (LS). At most one access is granted per cycle;
// read returns are steered back to the issuing requester RD_LAT cycles later.
// Build option: MEM_ARB_LS_PRIORITY_EN -- when defined, LS wins every
// conflict (fixed priority); otherwise conflicts are resolved round-robin.
// Ports:
//   clk, rst                       : clock, asynchronous active-low reset
//   if_req/if_addr                 : fetch read request
//   if_gnt/if_rvalid/if_rdata      : fetch accept, read return
//   ls_req/ls_we/ls_addr/ls_wdata  : load/store request
//   ls_gnt/ls_rvalid/ls_rdata      : load/store accept, load return
//   mem_address/mem_data/mem_wren  : memory drive
//   mem_q                          : memory read data
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);

  logic              grant_if;
  logic              grant_ls;
  rd_tag_t           tag_in;
  rd_tag_t           tag_head;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] ls_rdata_q;

  // Grants are forced low while reset is held so nothing reaches memory.
`ifdef MEM_ARB_LS_PRIORITY_EN
  always_comb begin
    grant_if = 1'b0;
    grant_ls = 1'b0;
    if (rst) begin
      grant_ls = ls_req;
      grant_if = if_req && !ls_req;
    end
  end
`else
  owner_e last_owner;
  owner_e last_owner_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_owner <= OWN_LS;
    else      last_owner <= last_owner_nxt;
  end

  always_comb begin
    grant_if       = 1'b0;
    grant_ls       = 1'b0;
    last_owner_nxt = last_owner;
    if (rst) begin
      if (if_req && ls_req) begin
        if (last_owner == OWN_LS) grant_if = 1'b1;
        else                      grant_ls = 1'b1;
      end else begin
        grant_if = if_req;
        grant_ls = ls_req;
      end
      if (grant_if)      last_owner_nxt = OWN_IF;
      else if (grant_ls) last_owner_nxt = OWN_LS;
    end
  end
`endif

  assign if_gnt = grant_if;
  assign ls_gnt = grant_ls;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (grant_if) begin
      mem_address = if_addr;
    end else if (grant_ls) begin
      mem_address = ls_addr;
      mem_data    = ls_wdata;
      mem_wren    = ls_we;
    end
  end

  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant_if || (grant_ls && !ls_we);
    tag_in.owner = grant_ls ? OWN_LS : OWN_IF;
  end

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk      (clk),
    .rst_n    (rst),
    .tag_in   (tag_in),
    .tag_head (tag_head)
  );

  assign if_rvalid = tag_head.valid && (tag_head.owner == OWN_IF);
  assign ls_rvalid = tag_head.valid && (tag_head.owner == OWN_LS);

  // Each side keeps its last returned word so the other side's return
  // does not disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= mem_q;
      if (ls_rvalid) ls_rdata_q <= mem_q;
    end
  end

  assign if_rdata = if_rvalid ? mem_q : if_rdata_q;
  assign ls_rdata = ls_rvalid ? mem_q : ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Three instances (RD_LAT = 1, 2, 3)
// share one stimulus stream; each has its own memory model. Expected outputs
// come from a transaction-level reference model (arbitration rule, return
// schedule by absolute cycle, reference memory contents).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [15:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;

  logic [2:0]  if_gnt_a, ls_gnt_a, if_rv_a, ls_rv_a, wren_a;
  logic [15:0] addr_a  [3];
  logic [31:0] data_a  [3];
  logic [31:0] if_rd_a [3];
  logic [31:0] ls_rd_a [3];
  logic [31:0] q_a     [3];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [15:0] a);
    return (a == 16'h0004) ? 32'hDEADBEEF : {a ^ 16'h5A5A, ~a};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned L = k + 1;
    logic [31:0] mem [65536];
    bit          wr_flag [65536];
    logic [31:0] qp [3];

    mem_port_arbiter #(
      .ADDR_W (16),
      .DATA_W (32),
      .RD_LAT (L)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .if_req      (if_req),
      .if_addr     (if_addr),
      .if_gnt      (if_gnt_a[k]),
      .if_rvalid   (if_rv_a[k]),
      .if_rdata    (if_rd_a[k]),
      .ls_req      (ls_req),
      .ls_we       (ls_we),
      .ls_addr     (ls_addr),
      .ls_wdata    (ls_wdata),
      .ls_gnt      (ls_gnt_a[k]),
      .ls_rvalid   (ls_rv_a[k]),
      .ls_rdata    (ls_rd_a[k]),
      .mem_address (addr_a[k]),
      .mem_data    (data_a[k]),
      .mem_wren    (wren_a[k]),
      .mem_q       (q_a[k])
    );

    // Synchronous single-port RAM, read-before-write, L-cycle read latency.
    always @(posedge clk) begin
      qp[0] <= wr_flag[addr_a[k]] ? mem[addr_a[k]] : init_word(addr_a[k]);
      qp[1] <= qp[0];
      qp[2] <= qp[1];
      if (wren_a[k]) begin
        mem[addr_a[k]]     <= data_a[k];
        wr_flag[addr_a[k]] <= 1'b1;
      end
    end
    assign q_a[k] = qp[L-1];
  end

  // ---------------- reference model ----------------
  bit           m_last_ls = 1'b1;
  bit           sv   [3][8];
  bit           sown [3][8];
  logic [31:0]  sdat [3][8];
  logic [31:0]  ref_mem [65536];
  bit           ref_wr  [65536];
  int unsigned  cyc = 0;
  bit           e_if_g, e_ls_g;
  logic [116:0] exp_v [3];

  function automatic logic [31:0] ref_read(input logic [15:0] a);
    return ref_wr[a] ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [116:0] obs(input int k);
    return {if_gnt_a[k], ls_gnt_a[k], wren_a[k], addr_a[k], data_a[k],
            if_rv_a[k], ls_rv_a[k],
            if_rv_a[k] ? if_rd_a[k] : 32'h0, ls_rv_a[k] ? ls_rd_a[k] : 32'h0};
  endfunction

  task automatic model_comb();
    bit riv, lsv;
    int unsigned s;
    e_if_g = 1'b0;
    e_ls_g = 1'b0;
    if (rst) begin
      if (if_req && ls_req) begin
`ifdef MEM_ARB_LS_PRIORITY_EN
        e_ls_g = 1'b1;
`else
        if (m_last_ls) e_if_g = 1'b1;
        else           e_ls_g = 1'b1;
`endif
      end else begin
        e_if_g = if_req;
        e_ls_g = ls_req;
      end
    end
    s = cyc % 8;
    for (int k = 0; k < 3; k++) begin
      riv = rst && sv[k][s] && !sown[k][s];
      lsv = rst && sv[k][s] && sown[k][s];
      exp_v[k] = {e_if_g, e_ls_g, e_ls_g & ls_we,
                  e_if_g ? if_addr : (e_ls_g ? ls_addr : 16'h0),
                  e_ls_g ? ls_wdata : 32'h0,
                  riv, lsv, riv ? sdat[k][s] : 32'h0, lsv ? sdat[k][s] : 32'h0};
    end
  endtask

  task automatic model_commit();
    logic [15:0] a;
    int unsigned s;
    model_comb();
    if (!rst) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 8; j++) sv[k][j] = 1'b0;
      m_last_ls = 1'b1;
    end else begin
      for (int k = 0; k < 3; k++) sv[k][cyc % 8] = 1'b0;
      if (e_if_g || e_ls_g) begin
        a = e_if_g ? if_addr : ls_addr;
        if (e_if_g || !ls_we) begin
          for (int k = 0; k < 3; k++) begin
            s = (cyc + k + 1) % 8;
            sv[k][s]   = 1'b1;
            sown[k][s] = e_ls_g;
            sdat[k][s] = ref_read(a);
          end
        end else begin
          ref_mem[a] = ls_wdata;
          ref_wr[a]  = 1'b1;
        end
        m_last_ls = e_ls_g;
      end
    end
    cyc++;
  endtask

  task automatic end_cycle();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_idle();
    end_cycle();
    end_cycle();
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 16'h1234;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h4321; ls_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); model_comb();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k] || obs(k) !== 117'h0) begin
          n_fail++;
          $display("FAIL reset cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
    rst = 1'b1;
    set_idle();
  endtask

  task automatic test_if_read();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if_req = (i == 0); if_addr = 16'h0004;
      @(negedge clk); model_comb();
      if (i == 0) begin
        n_chk++;
        if (if_gnt_a[0] !== 1'b1) begin
          n_fail++; $display("FAIL if_read_gnt got=%b exp=1", if_gnt_a[0]);
        end
      end
      if (i == 1) begin
        n_chk++;
        if (if_rv_a[0] !== 1'b1 || if_rd_a[0] !== 32'hDEADBEEF || ls_rv_a[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL if_read_data rv=%b data=%h lsrv=%b exp rv=1 data=deadbeef lsrv=0",
                   if_rv_a[0], if_rd_a[0], ls_rv_a[0]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL if_read cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_alternate();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if_req = (i < 4); if_addr = 16'h0010;
      ls_req = (i < 4); ls_we = 1'b0; ls_addr = 16'h0020;
      @(negedge clk); model_comb();
`ifndef MEM_ARB_LS_PRIORITY_EN
      if (i < 4) begin
        n_chk++;
        if (if_gnt_a[0] !== ((i % 2) == 0) || ls_gnt_a[0] !== ((i % 2) == 1)) begin
          n_fail++;
          $display("FAIL alternate_order cyc=%0d got if=%b ls=%b exp if=%b ls=%b",
                   i, if_gnt_a[0], ls_gnt_a[0], (i % 2) == 0, (i % 2) == 1);
        end
      end
`endif
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL alternate cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_store_load();
    for (int i = 0; i < 6; i++) begin
      ls_req = (i < 2); ls_we = (i == 0); ls_addr = 16'h0030;
      ls_wdata = (i == 0) ? 32'h12345678 : 32'h0;
      @(negedge clk); model_comb();
      if (i == 0) begin
        n_chk++;
        if (wren_a[0] !== 1'b1 || data_a[0] !== 32'h12345678) begin
          n_fail++;
          $display("FAIL store_drive got wren=%b data=%h exp wren=1 data=12345678", wren_a[0], data_a[0]);
        end
      end
      if (i == 2) begin
        n_chk++;
        if (ls_rv_a[0] !== 1'b1 || ls_rd_a[0] !== 32'h12345678) begin
          n_fail++;
          $display("FAIL load_after_store got rv=%b data=%h exp rv=1 data=12345678", ls_rv_a[0], ls_rd_a[0]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL store_load cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      if_req = (i < 3); if_addr = 16'h0040 + 16'(i);
      @(negedge clk); model_comb();
      if (i >= 3 && i < 6) begin
        n_chk++;
        if (if_rv_a[2] !== 1'b1 || if_rd_a[2] !== init_word(16'h0040 + 16'(i - 3))) begin
          n_fail++;
          $display("FAIL lat3_burst cyc=%0d got rv=%b data=%h exp rv=1 data=%h",
                   i, if_rv_a[2], if_rd_a[2], init_word(16'h0040 + 16'(i - 3)));
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL back_to_back cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if_req = (i == 0); if_addr = 16'h0070;
      rst = !(i == 1 || i == 2);
      @(negedge clk); model_comb();
      if (i >= 3) begin
        n_chk++;
        if (if_rv_a[1] !== 1'b0) begin
          n_fail++; $display("FAIL flush_no_rvalid cyc=%0d got=%b exp=0", i, if_rv_a[1]);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL reset_flush cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if_req = (i < 5); if_addr = 16'h0050;
      ls_req = (i < 5); ls_we = 1'b0; ls_addr = 16'h0060;
      @(negedge clk); model_comb();
`ifdef MEM_ARB_LS_PRIORITY_EN
      if (i < 5) begin
        n_chk++;
        if (ls_gnt_a[0] !== 1'b1 || if_gnt_a[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL ls_priority cyc=%0d got ls=%b if=%b exp ls=1 if=0", i, ls_gnt_a[0], if_gnt_a[0]);
        end
      end
`endif
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL contention cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
  endtask

  task automatic test_random();
    bit drop;
    for (int i = 0; i < 400; i++) begin
      drop = ($urandom_range(0, 7) == 0);
      if (!if_req || e_if_g || drop) begin
        if_req  = $urandom_range(0, 1) == 1;
        if_addr = 16'($urandom_range(0, 15));
      end
      drop = ($urandom_range(0, 7) == 0);
      if (!ls_req || e_ls_g || drop) begin
        ls_req   = $urandom_range(0, 1) == 1;
        ls_we    = $urandom_range(0, 2) == 0;
        ls_addr  = 16'($urandom_range(0, 15));
        ls_wdata = $urandom;
      end
      @(negedge clk); model_comb();
      for (int k = 0; k < 3; k++) begin
        n_chk++;
        if (obs(k) !== exp_v[k]) begin
          n_fail++;
          $display("FAIL random cyc=%0d L=%0d got=%h exp=%h", i, k + 1, obs(k), exp_v[k]);
        end
      end
      end_cycle();
    end
    set_idle();
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_if_read();
    test_alternate();
    test_store_load();
    test_back_to_back();
    test_reset_flush();
    test_contention();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
